lcd_cmd_sequencer: RTL

//  Upstream feeder for the LCD strobe-timing controller. Buffers RS-tagged bytes

---
 rtl/lcd_cmd_sequencer_pkg.sv | 53 +++++
 rtl/lcd_cmd_fifo.sv | 55 +++++
 rtl/lcd_cmd_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_sequencer_pkg.sv
// Shared definitions for the LCD command sequencer: FSM state encodings,
// HD44780 command constants, the power-on init ROM and a us-to-cycles helper.
package lcd_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        S_PWRUP  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_STROBE = 3'd3,
        S_ACK    = 3'd4,
        S_DONE   = 3'd5,
        S_DELAY  = 3'd6
    } state_t;

    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME      = 8'h02;
    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
    localparam logic [7:0] LCD_WAKE_8B   = 8'h30;
    localparam logic [7:0] LCD_DISP_OFF  = 8'h08;

    localparam int INIT_LONG_US = 4100;

    // Cycles for a microsecond interval, rounded up.
    function automatic logic [31:0] us_to_cycles(input longint us, input longint clk_hz);
        longint prod;
        prod = us * clk_hz;
        return 32'((prod + 64'sd999_999) / 64'sd1_000_000);
    endfunction

    // Power-on init sequence, all entries are commands (RS=0).
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = LCD_WAKE_8B;
            3'd1:    b = LCD_WAKE_8B;
            3'd2:    b = LCD_WAKE_8B;
            3'd3:    b = LCD_FUNC_8B2L;
            3'd4:    b = LCD_DISP_OFF;
            3'd5:    b = LCD_CLEAR;
            3'd6:    b = LCD_ENTRY_INC;
            default: b = LCD_DISP_ON;
        endcase
        return b;
    endfunction

    // Clear and home are the slow commands: RS=0, DB[7:2]==0, DB!=0.
    function automatic logic is_clr_home(input logic rs, input logic [7:0] db);
        return (!rs) && (db[7:2] == 6'd0) && (db != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Show-ahead FIFO for RS-tagged bytes. Occupancy count one bit wider than
// the pointers gives full/empty directly. A push while full is dropped even
// if a pop happens in the same cycle.
module lcd_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];

    // Storage array; no reset needed, occupancy guards reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_wdata;
    end

    // Pointers and occupancy; pointers wrap naturally modulo depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Feeds RS-tagged bytes from the host FIFO to the LCD strobe-timing
// controller as nCS/nWR write transactions, waiting on RDY and then the
// HD44780 execution time after each byte.
// Optional feature: define LCD_INIT_SEQ_EN to run the 8-entry power-on init
// ROM after the power-up wait.
//
// Handshake: a transaction asserts nCS/nWR low and holds them until rdy is
// seen low (controller accepted), then releases them and waits for rdy high
// before the post-write delay, so one pushed byte is exactly one LCD write.
// If rdy never falls within ACK_TIMEOUT cycles, err is set (sticky) and the
// sequencer moves on.
module lcd_cmd_sequencer
    import lcd_cmd_sequencer_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int FIFO_AW      = 4,
    parameter int CMD_DELAY_US = 40,
    parameter int CLR_DELAY_US = 1640,
    parameter int PWRUP_MS     = 15,
    parameter int ACK_TIMEOUT  = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    output logic       full,
    output logic       empty,
    input  logic       rdy,
    output logic       nCS,
    output logic       nWR,
    output logic       nRD,
    output logic       RS,
    output logic [7:0] DB,
    output logic       init_done,
    output logic       busy,
    output logic       err,
    output logic [2:0] o_dbg_state
);

    localparam logic [31:0] CMD_CYC   = us_to_cycles(64'(CMD_DELAY_US), 64'(CLK_HZ));
    localparam logic [31:0] CLR_CYC   = us_to_cycles(64'(CLR_DELAY_US), 64'(CLK_HZ));
    localparam logic [31:0] LONG_CYC  = us_to_cycles(64'(INIT_LONG_US), 64'(CLK_HZ));
    localparam logic [31:0] PWRUP_CYC = us_to_cycles(64'(PWRUP_MS) * 64'sd1000, 64'(CLK_HZ));
    localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_first;
    logic [31:0] r_cnt;
    logic [31:0] r_ack_cnt;
    logic        r_rs;
    logic [7:0]  r_db;
    logic        r_long;
    logic        r_init_done;
    logic        r_err;

    logic        w_cnt_zero;
    logic        w_ack_timeout;
    logic        w_pop;
    logic [8:0]  w_fifo_data;
    logic [31:0] w_delay_cyc;
    logic        w_in_init;
    logic        w_init_last;
    logic [7:0]  w_rom_byte;
    logic        w_rom_long;

    lcd_cmd_fifo #(
        .WIDTH (9),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr_en),
        .i_wdata (wr_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_data),
        .o_full  (full),
        .o_empty (empty)
    );

    assign w_cnt_zero    = (r_cnt == 32'd0);
    assign w_ack_timeout = (r_ack_cnt == ACK_LAST);
    assign w_pop         = (r_state == S_IDLE) && !empty;
    assign w_delay_cyc   = r_long ? LONG_CYC :
                           (is_clr_home(r_rs, r_db) ? CLR_CYC : CMD_CYC);

`ifdef LCD_INIT_SEQ_EN
    logic       r_in_init;
    logic [2:0] r_init_idx;

    // Steps through the init ROM; each entry advances when its delay ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_init  <= 1'b1;
            r_init_idx <= 3'd0;
        end else if (r_in_init && (r_state == S_DELAY) && w_cnt_zero) begin
            if (r_init_idx == 3'd7) r_in_init  <= 1'b0;
            else                    r_init_idx <= r_init_idx + 3'd1;
        end
    end

    assign w_in_init   = r_in_init;
    assign w_init_last = (r_init_idx == 3'd7);
    assign w_rom_byte  = init_rom(r_init_idx);
    assign w_rom_long  = (r_init_idx < 3'd2);
`else
    assign w_in_init   = 1'b0;
    assign w_init_last = 1'b1;
    assign w_rom_byte  = 8'h00;
    assign w_rom_long  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_PWRUP;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_PWRUP: begin
                if (!r_first && w_cnt_zero) begin
`ifdef LCD_INIT_SEQ_EN
                    w_next = S_INIT;
`else
                    w_next = S_IDLE;
`endif
                end
            end
            S_INIT:   w_next = S_STROBE;
            S_IDLE:   if (!empty) w_next = S_STROBE;
            S_STROBE: w_next = S_ACK;
            S_ACK: begin
                if (!rdy)               w_next = S_DONE;
                else if (w_ack_timeout) w_next = S_DELAY;
            end
            S_DONE:   if (rdy) w_next = S_DELAY;
            S_DELAY: begin
                if (w_cnt_zero)
                    w_next = (w_in_init && !w_init_last) ? S_INIT : S_IDLE;
            end
            default:  w_next = S_PWRUP;
        endcase
    end

    // Outputs decoded from the registered state; strobes drop with async reset.
    always_comb begin
        nCS         = 1'b1;
        nWR         = 1'b1;
        nRD         = 1'b1;
        busy        = 1'b0;
        RS          = r_rs;
        DB          = r_db;
        init_done   = r_init_done;
        err         = r_err;
        o_dbg_state = r_state;
        case (r_state)
            S_STROBE, S_ACK: begin
                nCS  = 1'b0;
                nWR  = 1'b0;
                busy = 1'b1;
            end
            S_DONE, S_DELAY: busy = 1'b1;
            default: ;
        endcase
    end

    // Delay counter: loads on entry to S_PWRUP (first cycle out of reset)
    // or S_DELAY, then counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= 1'b1;
            r_cnt   <= 32'd0;
        end else begin
            r_first <= 1'b0;
            if (r_first)
                r_cnt <= PWRUP_CYC;
            else if ((w_next == S_DELAY) && (r_state != S_DELAY))
                r_cnt <= w_delay_cyc;
            else if (!w_cnt_zero)
                r_cnt <= r_cnt - 32'd1;
        end
    end

    // Counts cycles spent in S_ACK for the acknowledge timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_ack_cnt <= 32'd0;
        else if (r_state != S_ACK) r_ack_cnt <= 32'd0;
        else                       r_ack_cnt <= r_ack_cnt + 32'd1;
    end

    // Latches the byte being written, from the FIFO head or the init ROM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs   <= 1'b0;
            r_db   <= 8'h00;
            r_long <= 1'b0;
        end else if (w_pop) begin
            r_rs   <= w_fifo_data[8];
            r_db   <= w_fifo_data[7:0];
            r_long <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_rs   <= 1'b0;
            r_db   <= w_rom_byte;
            r_long <= w_rom_long;
        end
    end

    // init_done rises when the FSM first reaches S_IDLE after power-up/init.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_init_done <= 1'b0;
        else if ((w_next == S_IDLE) && ((r_state == S_PWRUP) ||
                 ((r_state == S_DELAY) && w_in_init)))
            r_init_done <= 1'b1;
    end

    // Sticky acknowledge-timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if ((r_state == S_ACK) && rdy && w_ack_timeout)
            r_err <= 1'b1;
    end

endmodule
